// File: rtl/event_prio_encoder_pkg.sv
// Shared constants for the event priority encoder slice.
package event_prio_encoder_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

endpackage

// File: rtl/event_prio_encoder_prio_sel.sv
// Combinational find-first-set over N request bits, searching upward from
// i_start and wrapping to the lowest set bit when nothing lies at or above it.
module prio_sel #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;
  logic         w_hi_found;
  logic         w_lo_found;

  // The wrap search is split into "lowest set bit at or above start" and
  // "lowest set bit overall"; the latter is the wrapped result.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !w_lo_found) begin
        w_lo_idx   = W'(i);
        w_lo_found = 1'b1;
      end
      if (i_req[i] && !w_hi_found && (W'(i) >= i_start)) begin
        w_hi_idx   = W'(i);
        w_hi_found = 1'b1;
      end
    end
    o_found = w_lo_found;
    o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/event_prio_encoder.sv
// Registered N-to-log2(N) event encoder: captures one-cycle request pulses,
// arbitrates (fixed or round-robin) and issues one index per valid/ready transfer.
module event_prio_encoder
  import event_prio_encoder_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned RR = PRIO_FIXED,
  localparam int unsigned W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         clear_all,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] r_pending;
  logic [W-1:0] r_idx;
  logic         r_valid;
  logic [W-1:0] r_ptr;
  logic         r_overflow;

  logic [N-1:0] w_cand;
  logic [N-1:0] w_take;
  logic [W-1:0] w_start;
  logic [W-1:0] w_sel;
  logic [W-1:0] w_next_ptr;
  logic         w_found;
  logic         w_load;
  logic         w_dup;

  assign w_cand     = r_pending | req_in;
  assign w_start    = (RR == PRIO_RR) ? r_ptr : '0;
  assign w_load     = !r_valid || out_ready;
  assign w_dup      = |(req_in & r_pending);
  assign w_next_ptr = (w_sel == W'(N - 1)) ? '0 : w_sel + W'(1);

  prio_sel #(
    .N (N)
  ) u_sel (
    .i_req   (w_cand),
    .i_start (w_start),
    .o_idx   (w_sel),
    .o_found (w_found)
  );

  // A bit leaves the pending set the moment it enters the output register.
  always_comb begin
    w_take = '0;
    if (w_load && w_found) begin
      w_take[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else if (clear_all) begin
      r_pending  <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= w_cand & ~w_take;
      r_overflow <= r_overflow | w_dup;
      if (w_load) begin
        r_valid <= w_found;
        if (w_found) begin
          r_idx <= w_sel;
          r_ptr <= w_next_ptr;
        end
      end
    end
  end

  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign pending   = r_pending;
  assign overflow  = r_overflow;

endmodule
